ace_snoop_initiator: RTL and testbench
======================================

Name: ace_snoop_initiator

Overview:
- Interconnect-side snoop initiator. It sits between the coherency arbiter and the per-core snoop interfaces.
- On one coherent request it broadcasts an AC snoop to every cache except the originator, then collects every CR response.
- It drains all CD beats and returns one merged result: cache line, shared, dirty and error flags.
- It drives the AC/CR/CD interface as initiator, towards each core's cache-side snoop responder.

Parameters:
- NumPorts, 2, number of snooped cache ports (at least 1).
- DataWidth, 64, CD beat width in bits.
- LineBeats, 2, CD beats per cache line (line = DataWidth*LineBeats bits).

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset, asynchronous, active-low
- req_valid_i  input  1  coherent request valid
- req_ready_o  output  1  request accepted
- req_addr_i  input  ariane_ace AC addr width  snoop address
- req_snoop_i  input  snoop_pkg::acsnoop_t  READ_ONCE / READ_SHARED / READ_UNIQUE / CLEAN_INVALID
- req_src_i  input  $clog2(NumPorts) (min 1)  originating port, excluded from the snoop
- resp_valid_o  output  1  merged result valid
- resp_ready_i  input  1  result consumed
- resp_data_o  output  DataWidth*LineBeats  line; beat 0 in the LSBs
- resp_has_data_o  output  1  some responder transferred data
- resp_shared_o  output  1  OR of isShared
- resp_dirty_o  output  1  OR of passDirty
- resp_error_o  output  1  OR of CR error, plus protocol error
- snoop_req_o  output  NumPorts x ariane_ace::snoop_req_t  ac_valid, ac, cr_ready, cd_ready
- snoop_resp_i  input  NumPorts x ariane_ace::snoop_resp_t  ac_ready, cr_valid, cr_resp, cd_valid, cd

Behaviour:
- Reset: state IDLE. All outputs 0 except req_ready_o=1. All masks, flags, data and beat counter cleared.
- FSM states: IDLE, SEND_AC, WAIT_CR, RECV_CD, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch addr and snoop type.
  - target = all ports with the req_src_i bit cleared.
  - If target is empty, go to RESP with all flags 0. Otherwise ac_pend=target and cr_pend=target, then go to SEND_AC.
- SEND_AC:
  - ac_valid=1 on every port whose ac_pend bit is set.
  - Address and snoop fields are stable, from registers.
  - A bit is cleared in the cycle its ac_ready is seen.
  - Go to WAIT_CR the cycle after ac_pend reaches 0.
  - AC handshakes on different ports complete independently.
- WAIT_CR:
  - cr_ready=1 on ports with cr_pend set.
  - On each cr_valid&cr_ready: latch that port's cr_resp and clear its bit.
  - When cr_pend is 0:
    - shared, dirty and error = OR over target.
    - cd_pend = targets with dataTransfer=1.
    - sel = lowest-index set bit of cd_pend.
    - Go to RECV_CD if cd_pend is non-zero, else to RESP.
  - A CR that arrives before its port's AC handshake (not possible in SEND_AC) is not accepted early.
- RECV_CD:
  - cd_ready=1 on all ports with cd_pend set.
  - Beats from sel are written to line slot beat_q. beat_q increments per beat and wraps to 0 after LineBeats-1.
  - Beats from other data-transferring ports are drained and discarded.
  - A port's bit clears on a beat with cd.last.
  - Protocol error (sets error):
    - sel asserts last with beat_q != LineBeats-1;
    - sel sends its final beat without last; extra beats beyond LineBeats are discarded.
  - Go to RESP when cd_pend reaches 0.
- RESP:
  - resp_valid_o=1 with held outputs; has_data = (sel valid).
  - On resp_ready_i, go to IDLE. The same cycle does not accept a new request; req_ready_o=0 outside IDLE.
  - Outputs are stable until the handshake.
- Latency with zero-wait responders, from request to resp_valid_o: 3 + LineBeats cycles with data, 3 without.
- Reset mid-operation: immediate return to IDLE; all handshakes drop.
- CLEAN_INVALID follows the same flow; data is expected to be absent, but any CD is still drained.

Optional Feature:
- Macro: SNOOP_FILTER_EN.
- Defined: extra input snoop_en_i [NumPorts]. target = ~src_onehot & snoop_en_i, sampled at request accept. Disabled ports see no AC traffic.
- Undefined: the port does not exist; target = ~src_onehot.

Decomposition:
- snoop_pkg holds:
  - the state enum;
  - a function lowest_set_idx(mask);
  - the merged-response struct snoop_merge_t {data, has_data, shared, dirty, error}.
- acsnoop_t and crresp_t are reused as-is.
- One sub-module: snoop_cd_collector. It covers RECV_CD data capture, beat counter, drain mask and last/protocol checking.

Test Plan:
- NumPorts=2, src=0, READ_SHARED, port1 CR {dataTransfer=1, isShared=1}, CD 64'hA, 64'hB with last -> resp_data=128'hB_..._A, has_data=1, shared=1, latency 5 cycles.
- src=1, READ_ONCE, port0 CR dataTransfer=0 -> no CD accepted, resp has_data=0, all flags 0, latency 3.
- NumPorts=4, src=0, ports1 and 3 both transfer data, port3 CD arrives first -> data taken from port1, port3 beats drained, FSM reaches RESP only after both last beats.
- Port1 CR error=1 with passDirty=1 -> resp_error=1, resp_dirty=1; AC ready delayed 3 cycles -> AC fields held stable throughout.
- Selected port asserts last on beat 0 -> resp_error=1, FSM returns to IDLE after resp_ready.
- With SNOOP_FILTER_EN, snoop_en_i=4'b0010 and src=0 -> only port1 sees ac_valid; snoop_en_i=0 -> immediate RESP with flags 0.

Source files
------------

// File: rtl/snoop_pkg.sv
// rtl/snoop_pkg.sv - shared snoop channel types, FSM states and merge helpers
package snoop_pkg;

    localparam int unsigned AcAddrWidth  = 64;
    localparam int unsigned CdDataWidth  = 64;
    localparam int unsigned MaxLineWidth = 1024;

    typedef logic [3:0] acsnoop_t;

    localparam acsnoop_t READ_ONCE     = 4'b0000;
    localparam acsnoop_t READ_SHARED   = 4'b0001;
    localparam acsnoop_t READ_UNIQUE   = 4'b0111;
    localparam acsnoop_t CLEAN_INVALID = 4'b1001;

    typedef struct packed {
        logic wasUnique;
        logic isShared;
        logic passDirty;
        logic error;
        logic dataTransfer;
    } crresp_t;

    typedef struct packed {
        logic [AcAddrWidth-1:0] addr;
        acsnoop_t               snoop;
    } ac_chan_t;

    typedef struct packed {
        logic [CdDataWidth-1:0] data;
        logic                   last;
    } cd_chan_t;

    typedef struct packed {
        logic     ac_valid;
        ac_chan_t ac;
        logic     cr_ready;
        logic     cd_ready;
    } snoop_req_t;

    typedef struct packed {
        logic     ac_ready;
        logic     cr_valid;
        crresp_t  cr_resp;
        logic     cd_valid;
        cd_chan_t cd;
    } snoop_resp_t;

    typedef enum logic [2:0] {
        IDLE,
        SEND_AC,
        WAIT_CR,
        RECV_CD,
        RESP
    } state_e;

    typedef struct packed {
        logic [MaxLineWidth-1:0] data;
        logic                    has_data;
        logic                    shared;
        logic                    dirty;
        logic                    error;
    } snoop_merge_t;

    // Masks wider than 32 ports are not supported by this helper.
    function automatic logic [4:0] lowest_set_idx(input logic [31:0] mask);
        logic [4:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (mask[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/snoop_cd_collector.sv
// rtl/snoop_cd_collector.sv - CD drain, selected-port line capture and last/beat checking
module snoop_cd_collector
    import snoop_pkg::*;
#(
    parameter int unsigned NumPorts  = 2,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned LineBeats = 2,
    localparam int unsigned IdxW     = (NumPorts > 1) ? $clog2(NumPorts) : 1,
    localparam int unsigned LineW    = DataWidth * LineBeats
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                clear_i,
    input  logic                                start_i,
    input  logic                                active_i,
    input  logic [NumPorts-1:0]                 mask_i,
    input  logic [IdxW-1:0]                     sel_i,
    input  logic [NumPorts-1:0]                 cd_valid_i,
    input  logic [NumPorts-1:0]                 cd_last_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]  cd_data_i,
    output logic [NumPorts-1:0]                 cd_ready_o,
    output logic                                done_o,
    output logic                                proto_err_o,
    output logic [LineW-1:0]                    line_o
);

    localparam int unsigned BeatW = (LineBeats > 1) ? $clog2(LineBeats) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(LineBeats - 1);

    logic [NumPorts-1:0]                 pend_q;
    logic [NumPorts-1:0]                 hs;
    logic [NumPorts-1:0]                 pend_next;
    logic [IdxW-1:0]                     sel_q;
    logic [BeatW-1:0]                    beat_q;
    logic                                full_q;
    logic                                err_q;
    logic [LineBeats-1:0][DataWidth-1:0] line_q;
    logic                                sel_hs;
    logic                                sel_last;

    always_comb begin
        cd_ready_o = active_i ? pend_q : '0;
        hs         = cd_valid_i & cd_ready_o;
        pend_next  = pend_q & ~(hs & cd_last_i);
        done_o     = active_i && (pend_next == '0);
        sel_hs     = hs[sel_q];
        sel_last   = cd_last_i[sel_q];
    end

    // Once the selected port has filled the line, further beats only drain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '0;
            sel_q  <= '0;
            beat_q <= '0;
            full_q <= 1'b0;
            err_q  <= 1'b0;
            line_q <= '0;
        end else if (clear_i) begin
            pend_q <= '0;
            sel_q  <= '0;
            beat_q <= '0;
            full_q <= 1'b0;
            err_q  <= 1'b0;
            line_q <= '0;
        end else if (start_i) begin
            pend_q <= mask_i;
            sel_q  <= sel_i;
            beat_q <= '0;
            full_q <= 1'b0;
        end else if (active_i) begin
            pend_q <= pend_next;
            if (sel_hs && !full_q) begin
                line_q[beat_q] <= cd_data_i[sel_q];
                if (beat_q == LastBeat) begin
                    beat_q <= '0;
                    if (!sel_last) begin
                        full_q <= 1'b1;
                        err_q  <= 1'b1;
                    end
                end else begin
                    beat_q <= beat_q + 1'b1;
                    if (sel_last) err_q <= 1'b1;
                end
            end
        end
    end

    assign proto_err_o = err_q;
    assign line_o      = line_q;

endmodule

// File: rtl/ace_snoop_initiator.sv
// rtl/ace_snoop_initiator.sv - snoop broadcast/collect initiator; SNOOP_FILTER_EN adds snoop_en_i
module ace_snoop_initiator
    import snoop_pkg::*;
#(
    parameter int unsigned NumPorts  = 2,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned LineBeats = 2,
    localparam int unsigned IdxW     = (NumPorts > 1) ? $clog2(NumPorts) : 1,
    localparam int unsigned LineW    = DataWidth * LineBeats
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [AcAddrWidth-1:0]    req_addr_i,
    input  acsnoop_t                  req_snoop_i,
    input  logic [IdxW-1:0]           req_src_i,
    output logic                      resp_valid_o,
    input  logic                      resp_ready_i,
    output logic [LineW-1:0]          resp_data_o,
    output logic                      resp_has_data_o,
    output logic                      resp_shared_o,
    output logic                      resp_dirty_o,
    output logic                      resp_error_o,
`ifdef SNOOP_FILTER_EN
    input  logic [NumPorts-1:0]       snoop_en_i,
`endif
    output snoop_req_t [NumPorts-1:0] snoop_req_o,
    input  snoop_resp_t [NumPorts-1:0] snoop_resp_i
);

    state_e                         state_q;
    logic [AcAddrWidth-1:0]         addr_q;
    acsnoop_t                       snoop_q;
    logic [NumPorts-1:0]            ac_pend_q, cr_pend_q, cd_mask_q;
    logic                           shared_q, dirty_q, error_q, has_data_q;

    logic [NumPorts-1:0]            src_onehot, target;
    logic [NumPorts-1:0]            ac_hs, cr_hs, ac_pend_next, cr_pend_next, cd_mask_acc;
    logic [NumPorts-1:0]            cd_valid, cd_last, cd_ready;
    logic [NumPorts-1:0][DataWidth-1:0] cd_data;
    logic                           shared_acc, dirty_acc, error_acc;
    logic [IdxW-1:0]                sel_next;
    logic                           accept, cr_done, cd_done, proto_err;
    logic [LineW-1:0]               line;
    snoop_merge_t                   merge;

    always_comb begin
        src_onehot = NumPorts'(1) << req_src_i;
`ifdef SNOOP_FILTER_EN
        target     = ~src_onehot & snoop_en_i;
`else
        target     = ~src_onehot;
`endif
        accept      = (state_q == IDLE) && req_valid_i;
        shared_acc  = shared_q;
        dirty_acc   = dirty_q;
        error_acc   = error_q;
        cd_mask_acc = cd_mask_q;
        for (int i = 0; i < NumPorts; i++) begin
            ac_hs[i]    = (state_q == SEND_AC) && ac_pend_q[i] && snoop_resp_i[i].ac_ready;
            cr_hs[i]    = (state_q == WAIT_CR) && cr_pend_q[i] && snoop_resp_i[i].cr_valid;
            cd_valid[i] = snoop_resp_i[i].cd_valid;
            cd_last[i]  = snoop_resp_i[i].cd.last;
            cd_data[i]  = snoop_resp_i[i].cd.data;
            if (cr_hs[i]) begin
                shared_acc     = shared_acc | snoop_resp_i[i].cr_resp.isShared;
                dirty_acc      = dirty_acc  | snoop_resp_i[i].cr_resp.passDirty;
                error_acc      = error_acc  | snoop_resp_i[i].cr_resp.error;
                cd_mask_acc[i] = snoop_resp_i[i].cr_resp.dataTransfer;
            end
        end
        ac_pend_next = ac_pend_q & ~ac_hs;
        cr_pend_next = cr_pend_q & ~cr_hs;
        cr_done      = (state_q == WAIT_CR) && (cr_pend_next == '0);
        sel_next     = IdxW'(lowest_set_idx(32'(cd_mask_acc)));
    end

    always_comb begin
        snoop_req_o = '0;
        for (int i = 0; i < NumPorts; i++) begin
            snoop_req_o[i].ac_valid = (state_q == SEND_AC) && ac_pend_q[i];
            snoop_req_o[i].ac.addr  = addr_q;
            snoop_req_o[i].ac.snoop = snoop_q;
            snoop_req_o[i].cr_ready = (state_q == WAIT_CR) && cr_pend_q[i];
            snoop_req_o[i].cd_ready = cd_ready[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            snoop_q    <= '0;
            ac_pend_q  <= '0;
            cr_pend_q  <= '0;
            cd_mask_q  <= '0;
            shared_q   <= 1'b0;
            dirty_q    <= 1'b0;
            error_q    <= 1'b0;
            has_data_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req_valid_i) begin
                    addr_q     <= req_addr_i;
                    snoop_q    <= req_snoop_i;
                    cd_mask_q  <= '0;
                    shared_q   <= 1'b0;
                    dirty_q    <= 1'b0;
                    error_q    <= 1'b0;
                    has_data_q <= 1'b0;
                    ac_pend_q  <= target;
                    cr_pend_q  <= target;
                    state_q    <= (target == '0) ? RESP : SEND_AC;
                end
                SEND_AC: begin
                    ac_pend_q <= ac_pend_next;
                    if (ac_pend_next == '0) state_q <= WAIT_CR;
                end
                WAIT_CR: begin
                    cr_pend_q <= cr_pend_next;
                    shared_q  <= shared_acc;
                    dirty_q   <= dirty_acc;
                    error_q   <= error_acc;
                    cd_mask_q <= cd_mask_acc;
                    if (cr_done) begin
                        has_data_q <= (cd_mask_acc != '0);
                        state_q    <= (cd_mask_acc != '0) ? RECV_CD : RESP;
                    end
                end
                RECV_CD: if (cd_done) state_q <= RESP;
                RESP:    if (resp_ready_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    snoop_cd_collector #(
        .NumPorts  (NumPorts),
        .DataWidth (DataWidth),
        .LineBeats (LineBeats)
    ) u_cd_collector (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (accept),
        .start_i     (cr_done),
        .active_i    (state_q == RECV_CD),
        .mask_i      (cd_mask_acc),
        .sel_i       (sel_next),
        .cd_valid_i  (cd_valid),
        .cd_last_i   (cd_last),
        .cd_data_i   (cd_data),
        .cd_ready_o  (cd_ready),
        .done_o      (cd_done),
        .proto_err_o (proto_err),
        .line_o      (line)
    );

    always_comb begin
        merge          = '0;
        merge.data     = MaxLineWidth'(line);
        merge.has_data = has_data_q;
        merge.shared   = shared_q;
        merge.dirty    = dirty_q;
        merge.error    = error_q | proto_err;
    end

    assign req_ready_o     = (state_q == IDLE);
    assign resp_valid_o    = (state_q == RESP);
    assign resp_data_o     = merge.data[LineW-1:0];
    assign resp_has_data_o = merge.has_data;
    assign resp_shared_o   = merge.shared;
    assign resp_dirty_o    = merge.dirty;
    assign resp_error_o    = merge.error;

endmodule

// File: tb/tb_ace_snoop_initiator.sv
// tb/tb_ace_snoop_initiator.sv - bench for ace_snoop_initiator with scripted cache responders
module tb_ace_snoop_initiator;
    import snoop_pkg::*;

    localparam int NP = 4;
    localparam int DW = 64;
    localparam int LB = 2;
    localparam int LW = DW * LB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                req_valid = 1'b0;
    logic                req_ready;
    logic [63:0]         req_addr = '0;
    acsnoop_t            req_snoop = '0;
    logic [1:0]          req_src = '0;
    logic                resp_valid;
    logic                resp_ready = 1'b0;
    logic [LW-1:0]       resp_data;
    logic                resp_has_data, resp_shared, resp_dirty, resp_error;
    snoop_req_t [NP-1:0]  snoop_req;
    snoop_resp_t [NP-1:0] snoop_resp;
    logic [NP-1:0]       snoop_en = '1;

    ace_snoop_initiator #(.NumPorts(NP), .DataWidth(DW), .LineBeats(LB)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_addr_i      (req_addr),
        .req_snoop_i     (req_snoop),
        .req_src_i       (req_src),
        .resp_valid_o    (resp_valid),
        .resp_ready_i    (resp_ready),
        .resp_data_o     (resp_data),
        .resp_has_data_o (resp_has_data),
        .resp_shared_o   (resp_shared),
        .resp_dirty_o    (resp_dirty),
        .resp_error_o    (resp_error),
`ifdef SNOOP_FILTER_EN
        .snoop_en_i      (snoop_en),
`endif
        .snoop_req_o     (snoop_req),
        .snoop_resp_i    (snoop_resp)
    );

    // Responder scripts: phase 0 await AC, 1 give CR, 2 CD delay, 3 send CD, 4 done.
    int          ac_dly[NP];
    int          cd_dly[NP];
    crresp_t     cr_cfg[NP];
    logic [63:0] bdata[NP][8];
    logic        blast[NP][8];
    int          nbeats[NP];
    int          phase[NP];
    int          acnt[NP];
    int          dcnt[NP];
    int          bidx[NP];

    logic [NP-1:0] exp_tgt;
    logic [63:0]   exp_addr;
    acsnoop_t      exp_snoop;
    logic [LW-1:0] exp_data;
    logic          exp_has, exp_sh, exp_dirty, exp_err;

    int  n_pass = 0;
    int  n_total = 0;
    int  ac_count[NP];
    bit  checking = 1'b0;
    bit  resp_seen = 1'b0;
    logic [LW-1:0] cap_data;
    logic [3:0]    cap_flags;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void drive_resp();
        for (int p = 0; p < NP; p++) begin
            snoop_resp[p]          = '0;
            snoop_resp[p].ac_ready = (phase[p] == 0) && (acnt[p] >= ac_dly[p]);
            snoop_resp[p].cr_valid = (phase[p] == 1);
            snoop_resp[p].cr_resp  = cr_cfg[p];
            if (phase[p] == 3 && bidx[p] < nbeats[p]) begin
                snoop_resp[p].cd_valid = 1'b1;
                snoop_resp[p].cd.data  = bdata[p][bidx[p]];
                snoop_resp[p].cd.last  = blast[p][bidx[p]];
            end
        end
    endfunction

    task automatic clear_cfg();
        for (int p = 0; p < NP; p++) begin
            ac_dly[p] = 0; cd_dly[p] = 0; cr_cfg[p] = '0; nbeats[p] = 0;
            for (int b = 0; b < 8; b++) begin bdata[p][b] = '0; blast[p][b] = 1'b0; end
        end
    endtask

    // Reference result straight from the snoop rules: OR of CR flags over the
    // targets, line from the lowest data port, error on a misplaced last.
    task automatic model(input int src);
        int sel, k;
        exp_tgt = ~(NP'(1) << src) & snoop_en;
        exp_sh = 0; exp_dirty = 0; exp_err = 0; exp_data = '0; sel = -1;
        for (int p = 0; p < NP; p++) begin
            if (exp_tgt[p]) begin
                exp_sh    |= cr_cfg[p].isShared;
                exp_dirty |= cr_cfg[p].passDirty;
                exp_err   |= cr_cfg[p].error;
                if (cr_cfg[p].dataTransfer && sel < 0) sel = p;
            end
        end
        exp_has = (sel >= 0);
        if (sel >= 0) begin
            k = -1;
            for (int b = 0; b < nbeats[sel]; b++) begin
                if (b < LB) exp_data[b*DW +: DW] = bdata[sel][b];
                if (blast[sel][b]) begin k = b; break; end
            end
            if (k != LB - 1) exp_err = 1'b1;
        end
    endtask

    initial begin : responder
        bit [NP-1:0] ahs, aseen, chs, dhs;
        forever begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                ahs[p]   = snoop_req[p].ac_valid && snoop_resp[p].ac_ready;
                aseen[p] = snoop_req[p].ac_valid;
                chs[p]   = snoop_req[p].cr_ready && snoop_resp[p].cr_valid;
                dhs[p]   = snoop_req[p].cd_ready && snoop_resp[p].cd_valid;
            end
            @(posedge clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                case (phase[p])
                    0: if (ahs[p]) phase[p] = 1; else if (aseen[p]) acnt[p]++;
                    1: if (chs[p]) begin
                        if (!cr_cfg[p].dataTransfer) phase[p] = 4;
                        else if (cd_dly[p] == 0) phase[p] = 3;
                        else begin phase[p] = 2; dcnt[p] = cd_dly[p]; end
                    end
                    2: begin dcnt[p]--; if (dcnt[p] == 0) phase[p] = 3; end
                    3: if (dhs[p]) begin bidx[p]++; if (bidx[p] >= nbeats[p]) phase[p] = 4; end
                    default: ;
                endcase
            end
            drive_resp();
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (rst_n && checking) begin
                for (int p = 0; p < NP; p++) begin
                    if (snoop_req[p].ac_valid) begin
                        ac_count[p]++;
                        chk("ac_target", LW'(exp_tgt[p]), LW'(1));
                        chk("ac_addr", LW'(snoop_req[p].ac.addr), LW'(exp_addr));
                        chk("ac_snoop", LW'(snoop_req[p].ac.snoop), LW'(exp_snoop));
                    end
                end
                if (resp_valid) begin
                    chk("resp_data", resp_data, exp_data);
                    chk("resp_flags", LW'({resp_has_data, resp_shared, resp_dirty, resp_error}),
                        LW'({exp_has, exp_sh, exp_dirty, exp_err}));
                    chk("req_ready_busy", LW'(req_ready), LW'(0));
                    if (!resp_seen) begin
                        resp_seen = 1'b1;
                        cap_data  = resp_data;
                        cap_flags = {resp_has_data, resp_shared, resp_dirty, resp_error};
                        for (int p = 0; p < NP; p++)
                            if (exp_tgt[p] && cr_cfg[p].dataTransfer)
                                chk("cd_drained", LW'(bidx[p]), LW'(nbeats[p]));
                    end
                end
            end
        end
    end

    task automatic start_req(input int src, input acsnoop_t sn, input logic [63:0] addr);
        model(src);
        exp_addr  = addr;
        exp_snoop = sn;
        @(posedge clk);
        #2;
        for (int p = 0; p < NP; p++) begin
            phase[p] = 0; acnt[p] = 0; dcnt[p] = 0; bidx[p] = 0; ac_count[p] = 0;
        end
        drive_resp();
        resp_seen = 1'b0;
        checking  = 1'b1;
        req_valid = 1'b1;
        req_src   = 2'(src);
        req_snoop = sn;
        req_addr  = addr;
        @(negedge clk);
        chk("req_ready_idle", LW'(req_ready), LW'(1));
        @(posedge clk);
        #2;
        req_valid = 1'b0;
    endtask

    task automatic run_txn(input int src, input acsnoop_t sn, input logic [63:0] addr,
                           input int hold, output int lat);
        start_req(src, sn, addr);
        lat = 1;
        forever begin
            @(negedge clk);
            if (resp_valid) break;
            @(posedge clk);
            lat++;
            if (lat > 300) begin
                chk("resp_timeout", LW'(resp_valid), LW'(1));
                break;
            end
        end
        repeat (hold) @(posedge clk);
        @(posedge clk);
        #2;
        resp_ready = 1'b1;
        @(posedge clk);
        #2;
        resp_ready = 1'b0;
        @(negedge clk);
        chk("req_ready_after", LW'(req_ready), LW'(1));
        chk("resp_valid_after", LW'(resp_valid), LW'(0));
        checking = 1'b0;
    endtask

    initial begin : global_timeout
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int lat;
        clear_cfg();
        for (int p = 0; p < NP; p++) begin
            phase[p] = 4; acnt[p] = 0; dcnt[p] = 0; bidx[p] = 0; ac_count[p] = 0;
        end
        drive_resp();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", LW'(req_ready), LW'(1));
        chk("rst_resp", LW'({resp_valid, resp_has_data, resp_shared, resp_dirty, resp_error}), LW'(0));
        chk("rst_resp_data", resp_data, LW'(0));
        for (int p = 0; p < NP; p++)
            chk("rst_snoop_req", LW'(snoop_req[p]), LW'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Data from port 1, zero-wait responders.
        clear_cfg();
        cr_cfg[1].dataTransfer = 1'b1; cr_cfg[1].isShared = 1'b1;
        bdata[1][0] = 64'hA; bdata[1][1] = 64'hB; blast[1][1] = 1'b1; nbeats[1] = 2;
        run_txn(0, READ_SHARED, 64'h1000, 0, lat);
        chk("t1_latency", LW'(lat), LW'(5));
        chk("t1_data", cap_data, {64'hB, 64'hA});
        chk("t1_flags", LW'(cap_flags), LW'(4'b1100));

        // No data anywhere.
        clear_cfg();
        run_txn(1, READ_ONCE, 64'h2040, 0, lat);
        chk("t2_latency", LW'(lat), LW'(3));
        chk("t2_flags", LW'(cap_flags), LW'(0));
        chk("t2_ac_src_port", LW'(ac_count[1]), LW'(0));

        // Two data ports; port 3 streams first and is drained, line taken from port 1.
        clear_cfg();
        cr_cfg[1].dataTransfer = 1'b1; cd_dly[1] = 3;
        bdata[1][0] = 64'h11; bdata[1][1] = 64'h22; blast[1][1] = 1'b1; nbeats[1] = 2;
        cr_cfg[3].dataTransfer = 1'b1; cr_cfg[3].isShared = 1'b1;
        bdata[3][0] = 64'h33; bdata[3][1] = 64'h44; blast[3][1] = 1'b1; nbeats[3] = 2;
        run_txn(0, READ_SHARED, 64'h3000, 2, lat);
        chk("t3_latency", LW'(lat), LW'(8));
        chk("t3_data", cap_data, {64'h22, 64'h11});

        // CR error with passDirty, slow AC on port 1.
        clear_cfg();
        cr_cfg[1].error = 1'b1; cr_cfg[1].passDirty = 1'b1; ac_dly[1] = 3;
        run_txn(0, READ_UNIQUE, 64'h4000, 0, lat);
        chk("t4_latency", LW'(lat), LW'(6));
        chk("t4_flags", LW'(cap_flags), LW'(4'b0011));
        chk("t4_ac_hold", LW'(ac_count[1]), LW'(4));

        // Selected port asserts last on beat 0.
        clear_cfg();
        cr_cfg[1].dataTransfer = 1'b1;
        bdata[1][0] = 64'hC; blast[1][0] = 1'b1; nbeats[1] = 1;
        run_txn(0, READ_SHARED, 64'h5000, 0, lat);
        chk("t5_latency", LW'(lat), LW'(4));
        chk("t5_flags", LW'(cap_flags), LW'(4'b1001));
        chk("t5_data", cap_data, {64'h0, 64'hC});

        // Final beat without last, extra beat discarded.
        clear_cfg();
        cr_cfg[2].dataTransfer = 1'b1;
        bdata[2][0] = 64'h5; bdata[2][1] = 64'h6; bdata[2][2] = 64'h7; blast[2][2] = 1'b1;
        nbeats[2] = 3;
        run_txn(0, READ_SHARED, 64'h6000, 0, lat);
        chk("t6_latency", LW'(lat), LW'(6));
        chk("t6_data", cap_data, {64'h6, 64'h5});
        chk("t6_flags", LW'(cap_flags), LW'(4'b1001));

        // CLEAN_INVALID still drains CD.
        clear_cfg();
        cr_cfg[2].dataTransfer = 1'b1;
        bdata[2][0] = 64'hD0; bdata[2][1] = 64'hD1; blast[2][1] = 1'b1; nbeats[2] = 2;
        run_txn(3, CLEAN_INVALID, 64'h7000, 0, lat);
        chk("t7_latency", LW'(lat), LW'(5));
        chk("t7_data", cap_data, {64'hD1, 64'hD0});

        // Reset in the middle of SEND_AC.
        clear_cfg();
        ac_dly[1] = 10;
        start_req(0, READ_SHARED, 64'h8000);
        repeat (2) @(posedge clk);
        #2;
        checking = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        for (int p = 0; p < NP; p++)
            chk("t8_ac_dropped", LW'({snoop_req[p].ac_valid, snoop_req[p].cr_ready, snoop_req[p].cd_ready}), LW'(0));
        chk("t8_req_ready", LW'(req_ready), LW'(1));
        chk("t8_resp_valid", LW'(resp_valid), LW'(0));
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        clear_cfg();
        run_txn(2, READ_ONCE, 64'h9000, 0, lat);
        chk("t8_recover_latency", LW'(lat), LW'(3));

`ifdef SNOOP_FILTER_EN
        clear_cfg();
        snoop_en = 4'b0010;
        run_txn(0, READ_ONCE, 64'hA000, 0, lat);
        chk("f1_ac_port2", LW'(ac_count[2]), LW'(0));
        chk("f1_ac_port3", LW'(ac_count[3]), LW'(0));
        chk("f1_ac_port1", LW'(ac_count[1] > 0), LW'(1));
        snoop_en = 4'b0000;
        run_txn(0, READ_ONCE, 64'hB000, 0, lat);
        chk("f2_latency", LW'(lat), LW'(1));
        chk("f2_flags", LW'(cap_flags), LW'(0));
        snoop_en = '1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
